// File: rtl/modular_inverse_if.sv
// Start/result handshake bundle for the modular inverse unit.
// The requester drives the master side; the arithmetic block sits on the slave side.
interface modular_inverse_if #(
  parameter int WIDTH = 16
);
  logic             ready_in;
  logic [WIDTH-1:0] value_in;
  logic [WIDTH-1:0] modulus_in;
  logic [WIDTH-1:0] inverse_out;
  logic             exists_out;
  logic             busy_out;
  logic             valid_out;

  modport master (
    output ready_in, value_in, modulus_in,
    input  inverse_out, exists_out, busy_out, valid_out
  );

  modport slave (
    input  ready_in, value_in, modulus_in,
    output inverse_out, exists_out, busy_out, valid_out
  );
endinterface

// File: rtl/modular_inverse.sv
// Modular inverse x = a^-1 mod m by iterative extended Euclid with a bit-serial restoring divider.
// Define MODINV_ITER_COUNT_EN to add iter_count_out (quotient steps of the last job, saturating).
module modular_inverse #(
  parameter int WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  modular_inverse_if.slave   bus
`ifdef MODINV_ITER_COUNT_EN
  ,
  output logic [7:0]         iter_count_out
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIVIDE,
    UPDATE,
    FINAL
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    m_reg;
  logic [WIDTH-1:0]    r0;
  logic [WIDTH-1:0]    r1;
  logic signed [WIDTH:0] t0;
  logic signed [WIDTH:0] t1;
  // quo holds the dividend during DIVIDE and ends up holding the quotient.
  logic [WIDTH-1:0]    quo;
  logic [WIDTH-1:0]    rem;
  logic [CW-1:0]       div_cnt;
`ifdef MODINV_ITER_COUNT_EN
  logic [7:0]          step_cnt;
`endif

  logic [WIDTH:0]        trial;
  logic [WIDTH:0]        trial_diff;
  logic                  trial_ge;
  logic [WIDTH-1:0]      rem_next;
  logic signed [WIDTH+1:0] prod;
  logic signed [WIDTH:0] t1_next;
  logic signed [WIDTH:0] t0_wrapped;
  logic                  exists_next;
  logic [WIDTH-1:0]      inverse_next;

  // NOTE: blocking assignments are correct here because these are combinational temporaries;
  // every signal gets a value on every pass, so no latch is inferred.
  always_comb begin
    trial        = {rem, quo[WIDTH-1]};
    trial_ge     = (trial >= {1'b0, r1});
    trial_diff   = trial - {1'b0, r1};
    rem_next     = trial_ge ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];

    // |t| never exceeds m, so truncating the product to WIDTH+1 bits is lossless.
    prod         = $signed({2'b00, quo}) * $signed({t1[WIDTH], t1});
    t1_next      = t0 - $signed(prod[WIDTH:0]);

    t0_wrapped   = t0 + $signed({1'b0, m_reg});
    exists_next  = (m_reg >= WIDTH'(2)) && (r0 == WIDTH'(1));
    inverse_next = '0;
    if (exists_next) begin
      inverse_next = t0[WIDTH] ? t0_wrapped[WIDTH-1:0] : t0[WIDTH-1:0];
    end
  end

  // NOTE: the working registers are cleared in reset as well as the outputs, so an aborted
  // job leaves nothing behind that a later job could observe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      m_reg           <= '0;
      r0              <= '0;
      r1              <= '0;
      t0              <= '0;
      t1              <= '0;
      quo             <= '0;
      rem             <= '0;
      div_cnt         <= '0;
      bus.inverse_out <= '0;
      bus.exists_out  <= 1'b0;
      bus.busy_out    <= 1'b0;
      bus.valid_out   <= 1'b0;
`ifdef MODINV_ITER_COUNT_EN
      step_cnt        <= '0;
      iter_count_out  <= '0;
`endif
    end else begin
      bus.valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ready_in) begin
            m_reg        <= bus.modulus_in;
            r0           <= bus.modulus_in;
            r1           <= bus.value_in;
            t0           <= '0;
            t1           <= (WIDTH+1)'(1);
            bus.busy_out <= 1'b1;
`ifdef MODINV_ITER_COUNT_EN
            step_cnt     <= '0;
`endif
            state        <= CHECK;
          end
        end

        CHECK: begin
          if ((m_reg < WIDTH'(2)) || (r1 == '0)) begin
            state <= FINAL;
          end else begin
            quo     <= r0;
            rem     <= '0;
            div_cnt <= '0;
            state   <= DIVIDE;
          end
        end

        DIVIDE: begin
          rem     <= rem_next;
          quo     <= {quo[WIDTH-2:0], trial_ge};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DIV_LAST) begin
            state <= UPDATE;
          end
        end

        UPDATE: begin
          r0    <= r1;
          r1    <= rem;
          t0    <= t1;
          t1    <= t1_next;
`ifdef MODINV_ITER_COUNT_EN
          if (step_cnt != 8'hFF) begin
            step_cnt <= step_cnt + 8'd1;
          end
`endif
          state <= CHECK;
        end

        FINAL: begin
          bus.inverse_out <= inverse_next;
          bus.exists_out  <= exists_next;
          bus.busy_out    <= 1'b0;
          bus.valid_out   <= 1'b1;
`ifdef MODINV_ITER_COUNT_EN
          iter_count_out  <= step_cnt;
`endif
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_inverse.sv
// Scoreboard bench for modular_inverse: expectations queued at start, checked when valid_out pulses.
// Define MODINV_ITER_COUNT_EN here too to also check the step counter output.
module tb_modular_inverse;

  localparam int W = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  modular_inverse_if #(.WIDTH(W)) bus ();

`ifdef MODINV_ITER_COUNT_EN
  logic [7:0] iter_count;
`endif

  modular_inverse #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
`ifdef MODINV_ITER_COUNT_EN
    ,
    .iter_count_out (iter_count)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [W-1:0] inv;
    logic         ex;
    int           k;
    longint       start_cyc;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  logic   prev_valid = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic longint gcd(input longint x, input longint y);
    longint p = x, q = y, r;
    while (q != 0) begin
      r = p % q;
      p = q;
      q = r;
    end
    return p;
  endfunction

  // Reference extended Euclid on wide integers; also yields the quotient-step count k.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] m,
                       output logic [W-1:0] inv, output logic ex, output int k);
    longint r0 = longint'(m), r1 = longint'(a), s0 = 0, s1 = 1, q, tmp;
    k = 0;
    ex = 1'b0;
    inv = '0;
    if (m >= 2) begin
      while (r1 != 0) begin
        q = r0 / r1;
        tmp = r0 - q * r1; r0 = r1; r1 = tmp;
        tmp = s0 - q * s1; s0 = s1; s1 = tmp;
        k++;
      end
      ex = (r0 == 1);
      if (ex) inv = W'(((s0 % longint'(m)) + longint'(m)) % longint'(m));
    end
  endtask

  // Caller is at a negedge; the start is sampled at the following posedge (E0).
  task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] m,
                           input logic [W-1:0] inv, input logic ex, input int k);
    exp_t e;
    e.a = a; e.m = m; e.inv = inv; e.ex = ex; e.k = k; e.start_cyc = cyc;
    sb.push_back(e);
    bus.ready_in   = 1'b1;
    bus.value_in   = a;
    bus.modulus_in = m;
    @(negedge clk_in);
    bus.ready_in   = 1'b0;
    bus.value_in   = W'($urandom);
    bus.modulus_in = W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d jobs still pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk_in) begin
    exp_t   e;
    longint lat;
    if (bus.valid_out) begin
      total++;
      if (prev_valid) begin
        bad++;
        $display("FAIL valid_width: valid_out high in two consecutive cycles");
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stray_valid: valid_out with no job outstanding (inv=%0d)", bus.inverse_out);
      end else begin
        e = sb.pop_front();
        lat = cyc - e.start_cyc;
        total++;
        if (bus.inverse_out !== e.inv) begin
          bad++;
          $display("FAIL inverse a=%0d m=%0d: got %0d want %0d", e.a, e.m, bus.inverse_out, e.inv);
        end
        total++;
        if (bus.exists_out !== e.ex) begin
          bad++;
          $display("FAIL exists a=%0d m=%0d: got %0b want %0b", e.a, e.m, bus.exists_out, e.ex);
        end
        total++;
        if (lat != longint'(e.k * (W + 2) + 3)) begin
          bad++;
          $display("FAIL latency a=%0d m=%0d: got %0d want %0d", e.a, e.m, lat, e.k * (W + 2) + 3);
        end
        total++;
        if (bus.exists_out === 1'b1) begin
          if (bus.inverse_out >= e.m ||
              (longint'(e.a) * longint'(bus.inverse_out)) % longint'(e.m) != 1) begin
            bad++;
            $display("FAIL inverse_property a=%0d m=%0d: got x=%0d", e.a, e.m, bus.inverse_out);
          end
        end else if (e.m >= 2 && gcd(longint'(e.a), longint'(e.m)) == 1) begin
          bad++;
          $display("FAIL exists_property a=%0d m=%0d: got exists=0 want 1", e.a, e.m);
        end
`ifdef MODINV_ITER_COUNT_EN
        total++;
        if (iter_count !== 8'((e.k > 255) ? 255 : e.k)) begin
          bad++;
          $display("FAIL iter_count a=%0d m=%0d: got %0d want %0d", e.a, e.m, iter_count, e.k);
        end
`endif
      end
    end
    prev_valid <= bus.valid_out;
  end

  task automatic test_reset();
    bus.ready_in = 1'b0; bus.value_in = '0; bus.modulus_in = '0;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (bus.inverse_out !== '0 || bus.exists_out !== 1'b0 ||
        bus.busy_out !== 1'b0 || bus.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got inv=%0d ex=%0b busy=%0b valid=%0b want all 0",
               bus.inverse_out, bus.exists_out, bus.busy_out, bus.valid_out);
    end
  endtask

  task automatic test_directed();
    // a, m, inverse, exists, k
    int tbl [10][5] = '{
      '{3,     7,     5,     1, 2},
      '{17,    3120,  2753,  1, 4},
      '{6,     9,     0,     0, 2},
      '{0,     11,    0,     0, 0},
      '{10,    7,     5,     1, 4},
      '{3,     1,     0,     0, 0},
      '{5,     0,     0,     0, 0},
      '{1,     2,     1,     1, 1},
      '{65535, 65534, 1,     1, 3},
      '{2,     65535, 32768, 1, 2}
    };
    for (int i = 0; i < 10; i++) begin
      start_job(W'(tbl[i][0]), W'(tbl[i][1]), W'(tbl[i][2]), tbl[i][3] != 0, tbl[i][4]);
      total++;
      if (bus.busy_out !== 1'b1) begin
        bad++;
        $display("FAIL busy_after_start a=%0d m=%0d: got %0b want 1", tbl[i][0], tbl[i][1], bus.busy_out);
      end
      wait_done(2000);
      repeat (3) @(negedge clk_in);
      total++;
      if (bus.inverse_out !== W'(tbl[i][2]) || bus.valid_out !== 1'b0) begin
        bad++;
        $display("FAIL hold a=%0d m=%0d: got inv=%0d valid=%0b want inv=%0d valid=0",
                 tbl[i][0], tbl[i][1], bus.inverse_out, bus.valid_out, tbl[i][2]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    start_job(W'(3), W'(7), W'(5), 1'b1, 2);
    bus.ready_in = 1'b1; bus.value_in = W'(6); bus.modulus_in = W'(9);
    repeat (4) @(negedge clk_in);
    bus.ready_in = 1'b0;
    wait_done(2000);
    repeat (50) @(negedge clk_in);
    total++;
    if (bus.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore: got busy=%0b want 0 (ready while busy must not start a job)", bus.busy_out);
    end
  endtask

  task automatic test_reset_mid();
    start_job(W'(3), W'(7), W'(5), 1'b1, 2);
    repeat (5) @(negedge clk_in);
    rst_in = 1'b1;
    sb.delete();
    @(negedge clk_in);
    rst_in = 1'b0;
    total++;
    if (bus.inverse_out !== '0 || bus.exists_out !== 1'b0 ||
        bus.busy_out !== 1'b0 || bus.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: got inv=%0d ex=%0b busy=%0b valid=%0b want all 0",
               bus.inverse_out, bus.exists_out, bus.busy_out, bus.valid_out);
    end
    repeat (60) @(negedge clk_in);
    start_job(W'(3), W'(7), W'(5), 1'b1, 2);
    wait_done(2000);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    start_job(W'(17), W'(3120), W'(2753), 1'b1, 4);
    while (bus.valid_out !== 1'b1 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (bus.valid_out !== 1'b1 || bus.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_handoff: got valid=%0b busy=%0b want valid=1 busy=0", bus.valid_out, bus.busy_out);
    end
    start_job(W'(3), W'(7), W'(5), 1'b1, 2);
    total++;
    if (bus.busy_out !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%0b want 1", bus.busy_out);
    end
    wait_done(2000);
  endtask

  task automatic test_random();
    logic [W-1:0] a, m, inv;
    logic         ex;
    int           k;
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom);
      m = (i % 4 == 0) ? W'($urandom_range(0, 24)) : W'($urandom);
      if (i % 8 == 1) a = W'($urandom_range(0, 3));
      model(a, m, inv, ex, k);
      start_job(a, m, inv, ex, k);
      wait_done(2000);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (5) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
